// File: rtl/pcs_context_stack.sv
// Hardware interrupt context stack: pushes a packed register frame on every ack,
// restores the top frame ahead of mret and pops it on interrupt exit.
module pcs_context_stack #(
  parameter int NrSavedRegs   = 18,
  parameter int DataWidth     = 32,
  parameter int IrqLevelWidth = 8,
  parameter int Depth         = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [IrqLevelWidth-1:0]             irq_level_i,
  input  logic                                 irq_ack_i,
  input  logic                                 irq_exit_i,
  input  logic                                 next_mret_i,
  input  logic [NrSavedRegs*DataWidth-1:0]     store_data_i,
  output logic [NrSavedRegs*DataWidth-1:0]     restore_data_o,
  output logic                                 restore_en_o,
  output logic [IrqLevelWidth-1:0]             top_level_o,
  output logic [$clog2(Depth+1)-1:0]           depth_o,
  output logic                                 overflow_o,
  output logic                                 underflow_o
);

  localparam int FrameW = NrSavedRegs * DataWidth;
  localparam int SpW    = $clog2(Depth + 1);
  localparam int AddrW  = $clog2(Depth);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESTORE,
    ST_ARMED
  } state_e;

  state_e                   r_state;
  state_e                   w_next_state;
  logic [SpW-1:0]           r_sp;
  logic [IrqLevelWidth-1:0] r_top_level;
  logic                     r_overflow;
  logic                     r_underflow;
  logic [FrameW-1:0]        r_restore_data;
  logic [AddrW-1:0]         r_rd_addr;
  logic [FrameW-1:0]        r_mem [Depth];
  logic [IrqLevelWidth-1:0] r_lvl [Depth];

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_overwrite;
  logic             w_pop;
  logic             w_wr_en;
  logic [AddrW-1:0] w_wr_addr;
  logic [AddrW-1:0] w_top_addr;
  logic [AddrW-1:0] w_below_addr;
  logic             w_start;
  logic             w_restore_en;

  assign w_full       = (r_sp == SpW'(Depth));
  assign w_empty      = (r_sp == '0);
  assign w_top_addr   = AddrW'(r_sp - SpW'(1));
  assign w_below_addr = AddrW'(r_sp - SpW'(2));
  // Ack together with exit is a tail-chain: the new frame replaces the top one.
  // On an empty stack it degenerates into a plain push.
  assign w_push       = irq_ack_i && (!irq_exit_i || w_empty) && !w_full;
  assign w_overwrite  = irq_ack_i && irq_exit_i && !w_empty;
  assign w_pop        = irq_exit_i && !irq_ack_i && !w_empty;
  assign w_wr_en      = w_push || w_overwrite;
  assign w_wr_addr    = w_overwrite ? w_top_addr : AddrW'(r_sp);
  assign w_start      = (r_state == ST_IDLE) && next_mret_i && !w_empty
                        && !irq_ack_i && !irq_exit_i;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= store_data_i;
      r_lvl[w_wr_addr] <= irq_level_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sp        <= '0;
      r_top_level <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_sp        <= r_sp + SpW'(1);
        r_top_level <= irq_level_i;
      end else if (w_overwrite) begin
        r_top_level <= irq_level_i;
      end else if (w_pop) begin
        r_sp        <= r_sp - SpW'(1);
        r_top_level <= (r_sp == SpW'(1)) ? '0 : r_lvl[w_below_addr];
      end
      if (irq_ack_i && !irq_exit_i && w_full) r_overflow <= 1'b1;
      if (irq_exit_i && w_empty) r_underflow <= 1'b1;
    end
  end

  // Two-stage read: address captured when the restore starts, data registered in READ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_addr      <= '0;
      r_restore_data <= '0;
    end else begin
      if (w_start) r_rd_addr <= w_top_addr;
      if (r_state == ST_READ) r_restore_data <= r_mem[r_rd_addr];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next_state = ST_READ;
      ST_READ:    w_next_state = ST_RESTORE;
      ST_RESTORE: w_next_state = ST_ARMED;
      ST_ARMED:   w_next_state = ST_ARMED;
      default:    w_next_state = ST_IDLE;
    endcase
    // Preemption or an exit abandons any restore in flight.
    if (r_state != ST_IDLE && (irq_ack_i || irq_exit_i)) w_next_state = ST_IDLE;
  end

  always_comb begin
    w_restore_en = 1'b0;
    if (r_state == ST_RESTORE) w_restore_en = 1'b1;
  end

  assign restore_data_o = r_restore_data;
  assign restore_en_o   = w_restore_en;
  assign top_level_o    = r_top_level;
  assign depth_o        = r_sp;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_pcs_context_stack.sv
// Directed self-checking bench for pcs_context_stack (Depth=4, 18x32-bit frames).
module tb_pcs_context_stack;

  localparam int NrSavedRegs   = 18;
  localparam int DataWidth     = 32;
  localparam int IrqLevelWidth = 8;
  localparam int Depth         = 4;
  localparam int FrameW        = NrSavedRegs * DataWidth;
  localparam int SpW           = $clog2(Depth + 1);

  logic                     clk_i;
  logic                     rst_ni;
  logic [IrqLevelWidth-1:0] irq_level_i;
  logic                     irq_ack_i;
  logic                     irq_exit_i;
  logic                     next_mret_i;
  logic [FrameW-1:0]        store_data_i;
  logic [FrameW-1:0]        restore_data_o;
  logic                     restore_en_o;
  logic [IrqLevelWidth-1:0] top_level_o;
  logic [SpW-1:0]           depth_o;
  logic                     overflow_o;
  logic                     underflow_o;

  int total;
  int bad;

  pcs_context_stack #(
    .NrSavedRegs  (NrSavedRegs),
    .DataWidth    (DataWidth),
    .IrqLevelWidth(IrqLevelWidth),
    .Depth        (Depth)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .irq_level_i   (irq_level_i),
    .irq_ack_i     (irq_ack_i),
    .irq_exit_i    (irq_exit_i),
    .next_mret_i   (next_mret_i),
    .store_data_i  (store_data_i),
    .restore_data_o(restore_data_o),
    .restore_en_o  (restore_en_o),
    .top_level_o   (top_level_o),
    .depth_o       (depth_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Word 0 = mepc, word 1 = mcause, remaining words derived from mepc.
  function automatic logic [FrameW-1:0] make_frame(input logic [31:0] mepc,
                                                   input logic [7:0] level);
    logic [FrameW-1:0] f;
    f = '0;
    for (int k = 0; k < NrSavedRegs; k++) begin
      if (k == 0)      f[k*DataWidth +: DataWidth] = mepc;
      else if (k == 1) f[k*DataWidth +: DataWidth] = 32'h8000_0000 | {24'd0, level};
      else             f[k*DataWidth +: DataWidth] = mepc + 32'(k * 16);
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    irq_level_i  = '0;
    irq_ack_i    = 1'b0;
    irq_exit_i   = 1'b0;
    next_mret_i  = 1'b0;
    store_data_i = '0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic push(input logic [31:0] mepc, input logic [7:0] level);
    store_data_i = make_frame(mepc, level);
    irq_level_i  = level;
    irq_ack_i    = 1'b1;
    tick();
    irq_ack_i    = 1'b0;
  endtask

  task automatic pop();
    irq_exit_i = 1'b1;
    tick();
    irq_exit_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (restore_data_o !== '0) begin $display("[TB] FAIL reset_data got=%h want=0", restore_data_o); bad++; end
    total++; if (restore_en_o !== 1'b0) begin $display("[TB] FAIL reset_en got=%b want=0", restore_en_o); bad++; end
    total++; if (top_level_o !== '0) begin $display("[TB] FAIL reset_level got=%0d want=0", top_level_o); bad++; end
    total++; if (depth_o !== '0) begin $display("[TB] FAIL reset_depth got=%0d want=0", depth_o); bad++; end
    total++; if (overflow_o !== 1'b0) begin $display("[TB] FAIL reset_ovf got=%b want=0", overflow_o); bad++; end
    total++; if (underflow_o !== 1'b0) begin $display("[TB] FAIL reset_udf got=%b want=0", underflow_o); bad++; end
  endtask

  task automatic test_push();
    do_reset();
    push(32'h100, 8'd3);
    total++; if (depth_o !== 3'd1) begin $display("[TB] FAIL push1_depth got=%0d want=1", depth_o); bad++; end
    total++; if (top_level_o !== 8'd3) begin $display("[TB] FAIL push1_level got=%0d want=3", top_level_o); bad++; end
    push(32'h200, 8'd5);
    total++; if (depth_o !== 3'd2) begin $display("[TB] FAIL push2_depth got=%0d want=2", depth_o); bad++; end
    total++; if (top_level_o !== 8'd5) begin $display("[TB] FAIL push2_level got=%0d want=5", top_level_o); bad++; end
  endtask

  // mret held for 5 cycles: exactly one strobe, at the second cycle after T.
  task automatic test_restore();
    logic expEn;
    do_reset();
    push(32'h100, 8'd3);
    push(32'h200, 8'd5);
    next_mret_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      expEn = (c == 2);
      total++; if (restore_en_o !== expEn) begin $display("[TB] FAIL restore_en_c%0d got=%b want=%b", c, restore_en_o, expEn); bad++; end
      if (c == 2) begin
        total++; if (restore_data_o !== make_frame(32'h200, 8'd5)) begin $display("[TB] FAIL restore_data got=%h want=%h", restore_data_o, make_frame(32'h200, 8'd5)); bad++; end
      end
    end
    next_mret_i = 1'b0;
    pop();
    total++; if (depth_o !== 3'd1) begin $display("[TB] FAIL exit_depth got=%0d want=1", depth_o); bad++; end
    total++; if (top_level_o !== 8'd3) begin $display("[TB] FAIL exit_level got=%0d want=3", top_level_o); bad++; end
    total++; if (restore_data_o[31:0] !== 32'h200) begin $display("[TB] FAIL data_hold got=%h want=200", restore_data_o[31:0]); bad++; end
    total++; if (restore_en_o !== 1'b0) begin $display("[TB] FAIL exit_en got=%b want=0", restore_en_o); bad++; end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) push(32'(i * 32'h100), 8'(i));
    total++; if (depth_o !== 3'd4) begin $display("[TB] FAIL ovf_depth got=%0d want=4", depth_o); bad++; end
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL ovf_flag got=%b want=1", overflow_o); bad++; end
    total++; if (top_level_o !== 8'd4) begin $display("[TB] FAIL ovf_level got=%0d want=4", top_level_o); bad++; end
    next_mret_i = 1'b1;
    tick();
    next_mret_i = 1'b0;
    tick();
    total++; if (restore_en_o !== 1'b1) begin $display("[TB] FAIL ovf_en got=%b want=1", restore_en_o); bad++; end
    total++; if (restore_data_o !== make_frame(32'h400, 8'd4)) begin $display("[TB] FAIL ovf_data got=%h want=%h", restore_data_o, make_frame(32'h400, 8'd4)); bad++; end
    tick();
    pop();
    total++; if (overflow_o !== 1'b1) begin $display("[TB] FAIL ovf_sticky got=%b want=1", overflow_o); bad++; end
    total++; if (top_level_o !== 8'd3) begin $display("[TB] FAIL ovf_pop_level got=%0d want=3", top_level_o); bad++; end
  endtask

  task automatic test_underflow();
    do_reset();
    pop();
    total++; if (underflow_o !== 1'b1) begin $display("[TB] FAIL udf_flag got=%b want=1", underflow_o); bad++; end
    total++; if (depth_o !== 3'd0) begin $display("[TB] FAIL udf_depth got=%0d want=0", depth_o); bad++; end
    next_mret_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++; if (restore_en_o !== 1'b0) begin $display("[TB] FAIL udf_en_c%0d got=%b want=0", c, restore_en_o); bad++; end
    end
    next_mret_i = 1'b0;
  endtask

  task automatic test_tail_chain();
    do_reset();
    push(32'h100, 8'd3);
    push(32'h200, 8'd5);
    store_data_i = make_frame(32'h300, 8'd7);
    irq_level_i  = 8'd7;
    irq_ack_i    = 1'b1;
    irq_exit_i   = 1'b1;
    tick();
    irq_ack_i    = 1'b0;
    irq_exit_i   = 1'b0;
    total++; if (depth_o !== 3'd2) begin $display("[TB] FAIL tail_depth got=%0d want=2", depth_o); bad++; end
    total++; if (top_level_o !== 8'd7) begin $display("[TB] FAIL tail_level got=%0d want=7", top_level_o); bad++; end
    total++; if (underflow_o !== 1'b0) begin $display("[TB] FAIL tail_udf got=%b want=0", underflow_o); bad++; end
    next_mret_i = 1'b1;
    tick();
    next_mret_i = 1'b0;
    tick();
    total++; if (restore_data_o !== make_frame(32'h300, 8'd7)) begin $display("[TB] FAIL tail_data got=%h want=%h", restore_data_o, make_frame(32'h300, 8'd7)); bad++; end
    tick();
    pop();
    total++; if (top_level_o !== 8'd3) begin $display("[TB] FAIL tail_pop_level got=%0d want=3", top_level_o); bad++; end
    // Tail-chain on an empty stack acts as a push and flags underflow.
    do_reset();
    store_data_i = make_frame(32'h600, 8'd9);
    irq_level_i  = 8'd9;
    irq_ack_i    = 1'b1;
    irq_exit_i   = 1'b1;
    tick();
    irq_ack_i    = 1'b0;
    irq_exit_i   = 1'b0;
    total++; if (depth_o !== 3'd1) begin $display("[TB] FAIL tail0_depth got=%0d want=1", depth_o); bad++; end
    total++; if (underflow_o !== 1'b1) begin $display("[TB] FAIL tail0_udf got=%b want=1", underflow_o); bad++; end
    total++; if (top_level_o !== 8'd9) begin $display("[TB] FAIL tail0_level got=%0d want=9", top_level_o); bad++; end
  endtask

  task automatic test_preempt();
    do_reset();
    push(32'h100, 8'd3);
    next_mret_i = 1'b1;
    tick();
    next_mret_i = 1'b0;
    push(32'h700, 8'd6);
    for (int c = 1; c <= 3; c++) begin
      total++; if (restore_en_o !== 1'b0) begin $display("[TB] FAIL pre_en_c%0d got=%b want=0", c, restore_en_o); bad++; end
      tick();
    end
    total++; if (depth_o !== 3'd2) begin $display("[TB] FAIL pre_depth got=%0d want=2", depth_o); bad++; end
    total++; if (top_level_o !== 8'd6) begin $display("[TB] FAIL pre_level got=%0d want=6", top_level_o); bad++; end
    next_mret_i = 1'b1;
    tick();
    next_mret_i = 1'b0;
    total++; if (restore_en_o !== 1'b0) begin $display("[TB] FAIL pre_re_early got=%b want=0", restore_en_o); bad++; end
    tick();
    total++; if (restore_en_o !== 1'b1) begin $display("[TB] FAIL pre_re_en got=%b want=1", restore_en_o); bad++; end
    total++; if (restore_data_o !== make_frame(32'h700, 8'd6)) begin $display("[TB] FAIL pre_re_data got=%h want=%h", restore_data_o, make_frame(32'h700, 8'd6)); bad++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(32'h100, 8'd3);
    next_mret_i = 1'b1;
    tick();
    next_mret_i = 1'b0;
    tick();
    total++; if (restore_en_o !== 1'b1) begin $display("[TB] FAIL ar_pre_en got=%b want=1", restore_en_o); bad++; end
    #2;
    rst_ni = 1'b0;
    #1;
    total++; if (restore_en_o !== 1'b0) begin $display("[TB] FAIL ar_en got=%b want=0", restore_en_o); bad++; end
    total++; if (depth_o !== 3'd0) begin $display("[TB] FAIL ar_depth got=%0d want=0", depth_o); bad++; end
    total++; if (restore_data_o !== '0) begin $display("[TB] FAIL ar_data got=%h want=0", restore_data_o); bad++; end
    tick();
    rst_ni = 1'b1;
    tick();
    total++; if (restore_en_o !== 1'b0) begin $display("[TB] FAIL ar_after_en got=%b want=0", restore_en_o); bad++; end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_push();
    test_restore();
    test_overflow();
    test_underflow();
    test_tail_chain();
    test_preempt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
